// File: rtl/sum_bcd_converter_if.sv
// rtl/sum_bcd_converter_if.sv - request/result bundle between adder side and BCD converter
interface sum_bcd_converter_if;
  logic        start;
  logic [7:0]  sum;
  logic        carry_out;
  logic        overflow_indicator;
  logic        signed_mode;
  logic        busy;
  logic        done;
  logic [11:0] bcd;
  logic        sign;
  logic        error;

  // Requester side: presents operands and start, observes status and result
  modport master (
    output start, sum, carry_out, overflow_indicator, signed_mode,
    input  busy, done, bcd, sign, error
  );

  // Converter side
  modport slave (
    input  start, sum, carry_out, overflow_indicator, signed_mode,
    output busy, done, bcd, sign, error
  );
endinterface

// File: rtl/sum_bcd_converter.sv
// rtl/sum_bcd_converter.sv - sequential double-dabble converter of adder result to 3 BCD digits
module sum_bcd_converter (
  input  logic                 clk,
  input  logic                 reset,
  sum_bcd_converter_if.slave   bus
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state_q;
  logic [8:0]  value_q;
  logic [8:0]  value_d;
  logic [11:0] scratch_q;
  logic [11:0] scratch_d;
  logic [11:0] scratch_adj;
  logic [3:0]  cnt_q;
  logic        sign_cap_q;
  logic        err_cap_q;
  logic        busy_q;
  logic        done_q;
  logic [11:0] bcd_q;
  logic        sign_q;
  logic        error_q;

  logic [7:0]  mag;
  logic [8:0]  cap_value;
  logic        cap_sign;
  logic        cap_err;

  // Operand selection at capture: unsigned takes carry as value MSB, signed takes |sum|
  always_comb begin
    mag       = bus.sum[7] ? (~bus.sum + 8'd1) : bus.sum;
    cap_value = {bus.carry_out, bus.sum};
    cap_sign  = 1'b0;
    cap_err   = 1'b0;
    if (bus.signed_mode) begin
      cap_value = {1'b0, mag};
      cap_sign  = bus.sum[7];
      cap_err   = bus.overflow_indicator;
    end
  end

  // One double-dabble step: add 3 to digits >= 5, then shift value MSB into scratch
  always_comb begin
    scratch_adj = scratch_q;
    for (int d = 0; d < 3; d++) begin
      if (scratch_q[d*4 +: 4] >= 4'd5) begin
        scratch_adj[d*4 +: 4] = scratch_q[d*4 +: 4] + 4'd3;
      end
    end
    scratch_d = {scratch_adj[10:0], value_q[8]};
    value_d   = {value_q[7:0], 1'b0};
  end

  // Control FSM with registered status and result outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      value_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      sign_cap_q <= 1'b0;
      err_cap_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      sign_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            value_q    <= cap_value;
            scratch_q  <= '0;
            cnt_q      <= '0;
            sign_cap_q <= cap_sign;
            err_cap_q  <= cap_err;
            busy_q     <= 1'b1;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          scratch_q <= scratch_d;
          value_q   <= value_d;
          cnt_q     <= cnt_q + 4'd1;
          // Ninth shift has consumed every value bit; publish result
          if (cnt_q == 4'd8) begin
            bcd_q   <= scratch_d;
            sign_q  <= sign_cap_q;
            error_q <= err_cap_q;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.bcd   = bcd_q;
  assign bus.sign  = sign_q;
  assign bus.error = error_q;

endmodule

// File: tb/tb_sum_bcd_converter.sv
// tb/tb_sum_bcd_converter.sv - scoreboard bench for sum_bcd_converter
module tb_sum_bcd_converter;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   done_count;
  int   cyc;
  logic [13:0] exp_q[$];

  sum_bcd_converter_if bus ();

  sum_bcd_converter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [11:0] bcd_of(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Monitor: every done pulse pops one expected result
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.busy && bus.done) chk("busy_done_overlap", 16'(bus.busy & bus.done), 16'd0);
      if (bus.done) begin
        logic [13:0] e;
        done_count++;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 16'(exp_q.size()), 16'd1);
        end else begin
          e = exp_q.pop_front();
          chk("bcd", 16'(bus.bcd), 16'(e[13:2]));
          chk("sign", 16'(bus.sign), 16'(e[1]));
          chk("error", 16'(bus.error), 16'(e[0]));
        end
      end
    end
  end

  task automatic drive(input logic co, input logic [7:0] s, input logic oi, input logic sm);
    bus.carry_out          = co;
    bus.sum                = s;
    bus.overflow_indicator = oi;
    bus.signed_mode        = sm;
  endtask

  task automatic wait_done(output int bc);
    logic got;
    bc  = 0;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (bus.busy) bc++;
      if (bus.done) got = 1'b1;
    end
    chk("done_seen", 16'(got), 16'd1);
  endtask

  task automatic run_conv(input logic co, input logic [7:0] s, input logic oi, input logic sm,
                          input logic [13:0] e, output int bc);
    @(posedge clk); #1;
    drive(co, s, oi, sm);
    bus.start = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(bc);
  endtask

  logic [8:0]  ops_v [4];
  logic        ops_sm[4];
  logic [13:0] ops_e [4];

  initial begin
    int bc;
    int d0;
    int prev_cyc;
    total = 0; bad = 0; done_count = 0; cyc = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 16'(bus.busy), 16'd0);
    chk("rst_done", 16'(bus.done), 16'd0);
    chk("rst_bcd", 16'(bus.bcd), 16'h000);
    chk("rst_sign", 16'(bus.sign), 16'd0);
    chk("rst_error", 16'(bus.error), 16'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Unsigned max, busy exactly nine cycles
    run_conv(1'b1, 8'hFF, 1'b1, 1'b0, {12'h511, 2'b00}, bc);
    chk("busy_cycles", 16'(bc), 16'd9);

    // Small unsigned values
    run_conv(1'b0, 8'h00, 1'b0, 1'b0, {12'h000, 2'b00}, bc);
    run_conv(1'b0, 8'h09, 1'b0, 1'b0, {12'h009, 2'b00}, bc);
    run_conv(1'b1, 8'h2C, 1'b0, 1'b0, {12'h300, 2'b00}, bc);

    // Signed mode, carry_out held high throughout
    run_conv(1'b1, 8'h80, 1'b1, 1'b1, {12'h128, 2'b11}, bc);
    run_conv(1'b1, 8'h7F, 1'b0, 1'b1, {12'h127, 2'b00}, bc);
    run_conv(1'b1, 8'hF6, 1'b0, 1'b1, {12'h010, 2'b10}, bc);

    // Start during SHIFT is ignored
    @(posedge clk); #1;
    drive(1'b1, 8'h2C, 1'b0, 1'b0);
    bus.start = 1'b1;
    exp_q.push_back({12'h300, 2'b00});
    d0 = done_count;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.sum   = 8'h01;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(bc);
    repeat (15) @(negedge clk);
    chk("collision_done_count", 16'(done_count - d0), 16'd1);

    // Back-to-back with start held high
    ops_v[0] = 9'd511; ops_sm[0] = 1'b0; ops_e[0] = {12'h511, 2'b00};
    ops_v[1] = 9'd1;   ops_sm[1] = 1'b0; ops_e[1] = {12'h001, 2'b00};
    ops_v[2] = 9'h080; ops_sm[2] = 1'b1; ops_e[2] = {12'h128, 2'b10};
    ops_v[3] = 9'd99;  ops_sm[3] = 1'b0; ops_e[3] = {12'h099, 2'b00};
    @(posedge clk); #1;
    drive(ops_v[0][8], ops_v[0][7:0], 1'b0, ops_sm[0]);
    exp_q.push_back(ops_e[0]);
    bus.start = 1'b1;
    prev_cyc = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i < 3) begin
        drive(ops_v[i+1][8], ops_v[i+1][7:0], 1'b0, ops_sm[i+1]);
        exp_q.push_back(ops_e[i+1]);
      end else begin
        bus.start = 1'b0;
      end
      wait_done(bc);
      if (i > 0) chk("b2b_spacing", 16'(cyc - prev_cyc), 16'd10);
      prev_cyc = cyc;
    end

    // Reset during shift 5
    @(posedge clk); #1;
    drive(1'b0, 8'hFF, 1'b0, 1'b0);
    bus.start = 1'b1;
    exp_q.push_back({12'h255, 2'b00});
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    d0 = done_count;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 16'(bus.busy), 16'd0);
    chk("midrst_done", 16'(bus.done), 16'd0);
    chk("midrst_bcd", 16'(bus.bcd), 16'h000);
    repeat (15) @(negedge clk);
    chk("midrst_no_done", 16'(done_count - d0), 16'd0);
    run_conv(1'b0, 8'h2A, 1'b0, 1'b0, {12'h042, 2'b00}, bc);

    // Exhaustive unsigned sweep; overflow flag must not leak into error
    for (int v = 0; v < 512; v++) begin
      logic [8:0] vv;
      vv = 9'(v);
      run_conv(vv[8], vv[7:0], 1'($urandom_range(0, 1)), 1'b0, {bcd_of(v), 2'b00}, bc);
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
